// File: rtl/parking_pkg.sv
// Shared types and widths for the parking-lot datapath.
package parking_pkg;

  localparam int unsigned ELAPSED_W = 8;
  localparam int unsigned FEE_W     = 12;
  localparam int unsigned SLOT_W    = 2;

  typedef enum logic [1:0] {
    GATE_CLOSED  = 2'd0,
    GATE_OPEN    = 2'd1,
    GATE_PASSING = 2'd2
  } gate_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divide-by-DIV prescaler: counts 0..DIV-1 while en, one-cycle tick on wrap.
module tick_prescaler #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en & ~clr & (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/parking_datapath.sv
// Parking-lot datapath: session timer, fee latch, gate FSM with timeout, free-slot counter.
module parking_datapath
  import parking_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned RATE         = 2,
  parameter int unsigned MAX_SLOTS    = 3,
  parameter int unsigned GATE_TIMEOUT = 200
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 init,
  input  logic                 count,
  input  logic                 cal,
  input  logic                 up,
  input  logic                 down,
  input  logic                 en,
  input  logic                 dis,
  input  logic                 exit_req,
  output logic [SLOT_W-1:0]    num_veh,
  output logic                 done,
  output logic [ELAPSED_W-1:0] elapsed,
  output logic [FEE_W-1:0]     fee,
  output logic                 fee_valid,
  output logic                 reject,
  output logic                 gate_open,
  output logic                 avail_led,
  output logic                 full_led
);

  localparam int unsigned TO_W = $clog2(GATE_TIMEOUT + 1);
  localparam logic [TO_W-1:0]      TO_LAST   = TO_W'(GATE_TIMEOUT - 1);
  localparam logic [SLOT_W-1:0]    SLOTS_MAX = SLOT_W'(MAX_SLOTS);
  localparam logic [ELAPSED_W-1:0] EL_MAX    = '1;

  gate_state_t          state_q, state_d;
  logic [ELAPSED_W-1:0] elapsed_q, elapsed_d;
  logic [FEE_W-1:0]     fee_q, fee_d;
  logic [SLOT_W-1:0]    slots_q, slots_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 fee_valid_q, reject_q, done_q, avail_q, full_q;
  logic                 timer_tick, gate_tick;
  logic                 accept, pass_down, timeout_hit, gate_is_open;

  tick_prescaler #(.DIV(TICK_DIV)) u_timer_pre (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (init),
    .en    (count),
    .tick  (timer_tick)
  );

  tick_prescaler #(.DIV(TICK_DIV)) u_gate_pre (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (~gate_is_open),
    .en    (gate_is_open),
    .tick  (gate_tick)
  );

  assign gate_is_open = (state_q == GATE_OPEN);
  assign accept       = cal & up & (state_q == GATE_CLOSED);
  assign pass_down    = down & (state_q == GATE_OPEN);
  assign timeout_hit  = gate_tick & (to_cnt_q == TO_LAST);

  // Gate FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= GATE_CLOSED;
    else          state_q <= state_d;
  end

  // Gate FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GATE_CLOSED:  if (accept) state_d = GATE_OPEN;
      GATE_OPEN: begin
        if (pass_down)        state_d = GATE_PASSING;
        else if (timeout_hit) state_d = GATE_CLOSED;
      end
      GATE_PASSING: state_d = GATE_CLOSED;
      default:      state_d = GATE_CLOSED;
    endcase
  end

  // Gate FSM: outputs
  always_comb begin
    gate_open = (state_q != GATE_CLOSED);
  end

  always_comb begin
    elapsed_d = elapsed_q;
    if (init)
      elapsed_d = '0;
    else if (timer_tick && elapsed_q != EL_MAX)
      elapsed_d = elapsed_q + 1'b1;

    fee_d = fee_q;
    if (accept)
      fee_d = FEE_W'(elapsed_q) * FEE_W'(RATE);

    to_cnt_d = '0;
    if (gate_is_open)
      to_cnt_d = gate_tick ? to_cnt_q + 1'b1 : to_cnt_q;

    // A pass and an exit in the same cycle cancel out.
    slots_d = slots_q;
    if (pass_down && !exit_req) begin
      if (slots_q != '0) slots_d = slots_q - 1'b1;
    end else if (exit_req && !pass_down) begin
      if (slots_q != SLOTS_MAX) slots_d = slots_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      elapsed_q   <= '0;
      fee_q       <= '0;
      slots_q     <= SLOTS_MAX;
      to_cnt_q    <= '0;
      fee_valid_q <= 1'b0;
      reject_q    <= 1'b0;
      done_q      <= 1'b0;
      avail_q     <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      elapsed_q   <= elapsed_d;
      fee_q       <= fee_d;
      slots_q     <= slots_d;
      to_cnt_q    <= to_cnt_d;
      fee_valid_q <= accept;
      reject_q    <= cal & ~accept;
      done_q      <= (state_q != GATE_CLOSED) && (state_d == GATE_CLOSED);
      avail_q     <= en & ~dis;
      full_q      <= dis;
    end
  end

  assign num_veh   = slots_q;
  assign done      = done_q;
  assign elapsed   = elapsed_q;
  assign fee       = fee_q;
  assign fee_valid = fee_valid_q;
  assign reject    = reject_q;
  assign avail_led = avail_q;
  assign full_led  = full_q;

endmodule
